// File: rtl/fir_stream_driver.sv
// fir_stream_driver
// Host-side initiator for a streaming FIR filter input interface.
// - Collects NBR_OF_TAPS coefficient words from the host and replays them to the
//   filter as one contiguous s_set_coeffs burst, followed by a two-cycle gap.
// - Queues host samples in a small FIFO and streams them back-to-back with
//   s_axis_fir_tvalid. A pop is only issued when the result buffer is
//   guaranteed to have room for the resulting y_n.
// - Captures y_n Y_LATENCY cycles after each valid sample into a result FIFO
//   that the host drains with a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host_data/is_coef   host word and its kind (1 = coefficient, 0 = sample)
//   host_valid/ready    host word handshake
//   flush               level; streams a partially filled sample FIFO
//   x_n, s_set_coeffs,
//   s_axis_fir_tvalid   registered drive towards the FIR core
//   y_n                 FIR output
//   res_data/valid/ready result buffer head and handshake
//   busy                any activity or buffered data
//   coef_done           one-cycle pulse at the start of the post-burst gap
// NBR_OF_TAPS must be >= 2; FIFO_DEPTH and RES_DEPTH must be powers of 2.
`timescale 1ns / 1ps

module fir_stream_driver #(
  parameter int unsigned X_N_SIZE    = 8,
  parameter int unsigned Y_N_SIZE    = 14,
  parameter int unsigned NBR_OF_TAPS = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned Y_LATENCY   = 2,
  parameter int unsigned RES_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [X_N_SIZE-1:0] host_data,
  input  logic                host_is_coef,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic                flush,
  output logic [X_N_SIZE-1:0] x_n,
  output logic                s_set_coeffs,
  output logic                s_axis_fir_tvalid,
  input  logic [Y_N_SIZE-1:0] y_n,
  output logic [Y_N_SIZE-1:0] res_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy,
  output logic                coef_done
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = FAW + 1;
  localparam int unsigned RAW = $clog2(RES_DEPTH);
  localparam int unsigned RCW = RAW + 1;
  localparam int unsigned TCW = $clog2(NBR_OF_TAPS + 1);
  localparam int unsigned CCW = $clog2(RES_DEPTH + Y_LATENCY + 2) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StCoefFill,
    StCoefBurst,
    StCoefGap,
    StStream
  } state_e;

  state_e              r_state;
  logic [TCW-1:0]      r_cnt;
  logic [X_N_SIZE-1:0] r_coef [NBR_OF_TAPS];
  logic [X_N_SIZE-1:0] r_x_n;
  logic                r_set_coeffs;
  logic                r_tvalid;
  logic                r_coef_done;

  // Sample FIFO
  logic [X_N_SIZE-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]      r_fifo_wr;
  logic [FAW-1:0]      r_fifo_rd;
  logic [FCW-1:0]      r_fifo_cnt;
  logic [FCW-1:0]      w_fifo_cnt_d;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_fifo_push;
  logic                w_fifo_pop;

  // Result buffer
  logic [Y_N_SIZE-1:0] r_res_mem [RES_DEPTH];
  logic [RAW-1:0]      r_res_wr;
  logic [RAW-1:0]      r_res_rd;
  logic [RCW-1:0]      r_res_cnt;
  logic                w_res_push;
  logic                w_res_pop;

  // Delayed copies of tvalid; the last stage marks y_n as belonging to a sample
  logic [Y_LATENCY-1:0] r_pipe;
  logic [CCW-1:0]       w_inflight;
  logic                 w_credit;

  logic w_coef_ok;
  logic w_samp_ok;
  logic w_coef_acc;

  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_fifo_full  = (r_fifo_cnt == FCW'(FIFO_DEPTH));

  // The sample currently on x_n and every pipe stage still owe a result slot.
  always_comb begin
    w_inflight = CCW'(r_tvalid);
    for (int i = 0; i < int'(Y_LATENCY); i++) begin
      w_inflight = w_inflight + CCW'(r_pipe[i]);
    end
  end

  assign w_credit = (CCW'(r_res_cnt) + w_inflight + CCW'(1)) <= CCW'(RES_DEPTH);

  assign w_coef_ok  = ((r_state == StIdle) || (r_state == StCoefFill)) &&
                      w_fifo_empty && (w_inflight == '0);
  assign w_samp_ok  = ((r_state == StIdle) || (r_state == StStream)) && !w_fifo_full;
  assign host_ready = host_is_coef ? w_coef_ok : w_samp_ok;

  assign w_coef_acc   = host_valid && host_is_coef && w_coef_ok;
  assign w_fifo_push  = host_valid && !host_is_coef && w_samp_ok;
  assign w_fifo_pop   = (r_state == StStream) && !w_fifo_empty && w_credit;
  assign w_fifo_cnt_d = r_fifo_cnt + FCW'(w_fifo_push) - FCW'(w_fifo_pop);

  assign w_res_push = r_pipe[Y_LATENCY-1];
  assign res_valid  = (r_res_cnt != '0);
  assign w_res_pop  = res_valid && res_ready;
  assign res_data   = res_valid ? r_res_mem[r_res_rd] : '0;

  assign x_n               = r_x_n;
  assign s_set_coeffs      = r_set_coeffs;
  assign s_axis_fir_tvalid = r_tvalid;
  assign coef_done         = r_coef_done;
  assign busy              = (r_state != StIdle) || !w_fifo_empty || res_valid ||
                             (w_inflight != '0);

  // Control FSM with registered FIR-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_x_n        <= '0;
      r_set_coeffs <= 1'b0;
      r_tvalid     <= 1'b0;
      r_coef_done  <= 1'b0;
      for (int i = 0; i < int'(NBR_OF_TAPS); i++) begin
        r_coef[i] <= '0;
      end
    end else begin
      r_x_n        <= '0;
      r_set_coeffs <= 1'b0;
      r_tvalid     <= 1'b0;
      r_coef_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_coef_acc) begin
            r_coef[0] <= host_data;
            r_cnt     <= TCW'(1);
            r_state   <= StCoefFill;
          end else if (w_fifo_full || (flush && !w_fifo_empty)) begin
            r_state <= StStream;
          end
        end
        StCoefFill: begin
          if (w_coef_acc) begin
            r_coef[r_cnt] <= host_data;
            if (r_cnt == TCW'(NBR_OF_TAPS - 1)) begin
              // First burst cycle repeats coef[0]; the filter discards it.
              r_cnt        <= '0;
              r_set_coeffs <= 1'b1;
              r_x_n        <= r_coef[0];
              r_state      <= StCoefBurst;
            end else begin
              r_cnt <= r_cnt + TCW'(1);
            end
          end
        end
        StCoefBurst: begin
          // r_cnt is the burst cycle being shown; load the next one's word.
          if (r_cnt == TCW'(NBR_OF_TAPS)) begin
            r_cnt       <= '0;
            r_coef_done <= 1'b1;
            r_state     <= StCoefGap;
          end else begin
            r_set_coeffs <= 1'b1;
            r_x_n        <= r_coef[r_cnt];
            r_cnt        <= r_cnt + TCW'(1);
          end
        end
        StCoefGap: begin
          if (r_cnt == '0) begin
            r_cnt <= TCW'(1);
          end else begin
            r_cnt   <= '0;
            r_state <= StIdle;
          end
        end
        StStream: begin
          r_tvalid <= w_fifo_pop;
          r_x_n    <= w_fifo_pop ? r_fifo_mem[r_fifo_rd] : '0;
          if (w_fifo_cnt_d == '0) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fifo_push) begin
      r_fifo_mem[r_fifo_wr] <= host_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_wr  <= '0;
      r_fifo_rd  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_fifo_push) begin
        r_fifo_wr <= r_fifo_wr + FAW'(1);
      end
      if (w_fifo_pop) begin
        r_fifo_rd <= r_fifo_rd + FAW'(1);
      end
      r_fifo_cnt <= w_fifo_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= r_tvalid;
      for (int i = 1; i < int'(Y_LATENCY); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_res_push) begin
      r_res_mem[r_res_wr] <= y_n;
    end
  end

  // Credit check on every pop guarantees a push never meets a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) begin
        r_res_wr <= r_res_wr + RAW'(1);
      end
      if (w_res_pop) begin
        r_res_rd <= r_res_rd + RAW'(1);
      end
      r_res_cnt <= r_res_cnt + RCW'(w_res_push) - RCW'(w_res_pop);
    end
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Testbench for fir_stream_driver. A stand-in filter returns y_n = 3*x exactly
// Y_LATENCY cycles after a valid sample and a junk value otherwise, so any
// capture at the wrong cycle shows up in the result scoreboard.
`timescale 1ns / 1ps

module tb_fir_stream_driver;

  localparam int unsigned XW  = 8;
  localparam int unsigned YW  = 14;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XW-1:0] host_data;
  logic          host_is_coef;
  logic          host_valid;
  logic          host_ready;
  logic          flush;
  logic [XW-1:0] x_n;
  logic          s_set_coeffs;
  logic          s_axis_fir_tvalid;
  logic [YW-1:0] y_n;
  logic [YW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          coef_done;

  int n_vec = 0;
  int n_err = 0;

  logic [XW-1:0] exp_coef [$];
  logic [XW-1:0] exp_x    [$];
  logic [YW-1:0] exp_res  [$];

  always #5 clk = ~clk;

  fir_stream_driver #(
    .X_N_SIZE   (XW),
    .Y_N_SIZE   (YW),
    .NBR_OF_TAPS(3),
    .FIFO_DEPTH (4),
    .Y_LATENCY  (LAT),
    .RES_DEPTH  (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .host_data        (host_data),
    .host_is_coef     (host_is_coef),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .flush            (flush),
    .x_n              (x_n),
    .s_set_coeffs     (s_set_coeffs),
    .s_axis_fir_tvalid(s_axis_fir_tvalid),
    .y_n              (y_n),
    .res_data         (res_data),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .busy             (busy),
    .coef_done        (coef_done)
  );

  // Stand-in filter
  logic [LAT-1:0] d_v;
  logic [XW-1:0]  d_x [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_v <= '0;
      for (int i = 0; i < int'(LAT); i++) d_x[i] <= '0;
    end else begin
      d_v[0] <= s_axis_fir_tvalid;
      d_x[0] <= x_n;
      for (int i = 1; i < int'(LAT); i++) begin
        d_v[i] <= d_v[i-1];
        d_x[i] <= d_x[i-1];
      end
    end
  end

  assign y_n = d_v[LAT-1] ? ({6'd0, d_x[LAT-1]} * 14'd3) : 14'h2AAA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_set_coeffs) begin
        if (exp_coef.size() == 0) fail_now("coef_beat", "unexpected coefficient beat");
        else chk("coef_x_n", x_n, exp_coef.pop_front());
      end
      if (s_axis_fir_tvalid) begin
        if (exp_x.size() == 0) fail_now("sample_beat", "unexpected sample beat");
        else chk("sample_x_n", x_n, exp_x.pop_front());
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) fail_now("res_beat", "unexpected result beat");
        else chk("res_data", res_data, exp_res.pop_front());
      end
    end
  end

  // Offer one word and hold it until accepted (bounded)
  task automatic send(input logic [XW-1:0] d, input logic c);
    bit ok = 1'b0;
    host_data    = d;
    host_is_coef = c;
    host_valid   = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = host_ready;
      @(posedge clk);
      #1;
    end
    host_valid = 1'b0;
    if (!ok) fail_now("send", "host word never accepted");
  endtask

  // Called on burst cycle 0: 4 burst cycles, 2 gap cycles, then coef ready again
  task automatic check_burst(input string name);
    logic [2:0] e;
    host_is_coef = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e = {(i < 4) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0, (i == 6) ? 1'b1 : 1'b0};
      chk(name, {29'd0, s_set_coeffs, coef_done, host_ready}, {29'd0, e});
    end
    chk({name, "_coef_left"}, exp_coef.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tvalid(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_axis_fir_tvalid && t < 60);
    if (!s_axis_fir_tvalid) fail_now(name, "tvalid never rose");
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 200);
    if (busy) fail_now(name, "busy never fell");
    else begin
      chk({name, "_x_left"}, exp_x.size(), 0);
      chk({name, "_res_left"}, exp_res.size(), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    host_data    = '0;
    host_is_coef = 1'b0;
    host_valid   = 1'b0;
    flush        = 1'b0;
    res_ready    = 1'b1;

    // Reset state
    #12;
    chk("rst_host_ready", host_ready, 1);
    chk("rst_set_coeffs", s_set_coeffs, 0);
    chk("rst_tvalid", s_axis_fir_tvalid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coef_done", coef_done, 0);
    chk("rst_x_n", x_n, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Coefficient load: burst x_n 01,01,03,00
    exp_coef = '{8'h01, 8'h01, 8'h03, 8'h00};
    send(8'h01, 1'b1);
    send(8'h03, 1'b1);
    send(8'h00, 1'b1);
    check_burst("burst1");

    // Full stream: FIFO full starts it, 4 back-to-back beats
    exp_x   = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_res = '{14'h030, 14'h060, 14'h090, 14'h0C0};
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    wait_tvalid("stream_start");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_run", s_axis_fir_tvalid, 1);
    end
    @(negedge clk);
    chk("stream_end", s_axis_fir_tvalid, 0);
    wait_idle("stream");

    // Backpressure: 8 samples, results held
    res_ready = 1'b0;
    exp_x     = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_res   = '{14'h003, 14'h006, 14'h009, 14'h00C, 14'h00F, 14'h012, 14'h015, 14'h018};
    for (int i = 1; i <= 8; i++) send(XW'(i), 1'b0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_stalled", s_axis_fir_tvalid, 0);
    end
    host_is_coef = 1'b0;
    #1;
    chk("bp_fifo_full", host_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_res_head", res_data, 14'h003);
    chk("bp_x_left", exp_x.size(), 4);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_idle("bp");

    // Flush of a partial FIFO
    exp_x   = '{8'h05, 8'hFB};
    exp_res = '{14'h00F, 14'h2F1};
    send(8'h05, 1'b0);
    send(8'hFB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_wait", s_axis_fir_tvalid, 0);
    end
    chk("flush_busy", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    wait_tvalid("flush_start");
    @(negedge clk);
    chk("flush_run", s_axis_fir_tvalid, 1);
    @(negedge clk);
    chk("flush_end", s_axis_fir_tvalid, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_idle("flush");

    // Hold-off: coefficient offered while samples are pending
    exp_x   = '{8'h11, 8'h22, 8'h33};
    exp_res = '{14'h033, 14'h066, 14'h099};
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    host_data    = 8'h02;
    host_is_coef = 1'b1;
    host_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("holdoff_ready", host_ready, 0);
    end
    @(posedge clk);
    #1;
    flush    = 1'b1;
    exp_coef = '{8'h02, 8'h02, 8'h05, 8'h07};
    send(8'h02, 1'b1);
    chk("holdoff_drained", exp_x.size(), 0);
    flush = 1'b0;
    send(8'h05, 1'b1);
    send(8'h07, 1'b1);
    check_burst("burst2");
    wait_idle("holdoff");

    // Async reset during burst cycle 2
    exp_coef = '{8'h0A, 8'h0A, 8'h0B, 8'h0C};
    send(8'h0A, 1'b1);
    send(8'h0B, 1'b1);
    send(8'h0C, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_set_coeffs", s_set_coeffs, 0);
    chk("arst_tvalid", s_axis_fir_tvalid, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_coef_done", coef_done, 0);
    chk("arst_x_n", x_n, 0);
    chk("arst_host_ready", host_ready, 1);
    chk("arst_coef_seen", exp_coef.size(), 2);
    exp_coef.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_coef = '{8'h04, 8'h04, 8'h05, 8'h06};
    send(8'h04, 1'b1);
    send(8'h05, 1'b1);
    send(8'h06, 1'b1);
    check_burst("burst3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Host-side initiator for the FIR input interface. It drives x_n, s_set_coeffs and s_axis_fir_tvalid, and collects y_n.
- Buffers host coefficient words and replays them to the filter as one contiguous configuration burst.
- Queues host samples in a FIFO and streams them back-to-back. Captures filter results into a backpressured result buffer.
- Sits between the tt05 pin-level host logic and the FIR core.

Parameters:
- X_N_SIZE, 8, sample/coefficient word width
- Y_N_SIZE, 14, filter output width
- NBR_OF_TAPS, 3, coefficients per configuration burst
- FIFO_DEPTH, 4, sample FIFO entries (power of 2)
- Y_LATENCY, 2, cycles from a sample driven with tvalid=1 to its y_n being valid
- RES_DEPTH, 4, result buffer entries (must be >= Y_LATENCY+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- host_data  in  X_N_SIZE  coefficient or sample word
- host_is_coef  in  1  1=host_data is a coefficient, 0=sample
- host_valid  in  1  host word valid
- host_ready  out  1  word accepted when host_valid&host_ready
- flush  in  1  level; stream a partially filled FIFO
- x_n  out  X_N_SIZE  data to FIR
- s_set_coeffs  out  1  FIR coefficient-shift strobe
- s_axis_fir_tvalid  out  1  FIR sample valid
- y_n  in  Y_N_SIZE  FIR output
- res_data  out  Y_N_SIZE  head of result buffer
- res_valid  out  1  result buffer non-empty
- res_ready  in  1  pops result when res_valid&res_ready
- busy  out  1  state != IDLE or FIFO/result/in-flight non-empty
- coef_done  out  1  one-cycle pulse at end of coefficient burst

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO, coef counter, result buffer and in-flight pipe cleared. All outputs 0, except host_ready, which takes its combinational value (sample path ready because FIFO empty).
- States: IDLE, COEF_FILL, COEF_BURST, COEF_GAP, STREAM.
- host_ready, coefficient word: 1 only in IDLE/COEF_FILL, and only with FIFO empty and in-flight count 0.
- host_ready, sample word: !fifo_full in IDLE/STREAM; 0 in COEF_FILL/COEF_BURST/COEF_GAP.
- IDLE -> COEF_FILL on the first accepted coefficient, stored at coef[0].
- COEF_FILL: stores coef[cnt] per accepted word. After word NBR_OF_TAPS-1 is stored, next state is COEF_BURST.
- COEF_BURST: exactly NBR_OF_TAPS+1 cycles with s_set_coeffs=1 and tvalid=0.
  - Burst cycle 0: x_n=coef[0].
  - Burst cycle k (k≥1): x_n=coef[k-1].
- COEF_GAP: 2 cycles with s_set_coeffs=0, tvalid=0, x_n=0. coef_done pulses in the first gap cycle. Then IDLE.
- IDLE -> STREAM when FIFO full, or when flush=1 and FIFO non-empty.
- STREAM, per cycle:
  - If FIFO non-empty and credit is available: pop, x_n=popped word, tvalid=1.
  - Otherwise tvalid=0 and x_n=0.
  - FIFO empty at a cycle boundary -> IDLE.
- Credit rule: pop allowed only if result occupancy + in-flight count + 1 <= RES_DEPTH. A stall (tvalid=0) is permitted and resets filter history; the bench treats it as a restart.
- In-flight pipe: Y_LATENCY-deep shift of the tvalid bit. When the pipe output is 1, y_n is written into the result buffer that cycle. No result is ever dropped.
- Result buffer: FIFO of RES_DEPTH entries; res_data shows the head combinationally.
  - Simultaneous push and pop is allowed, including when full.
  - Pop and push on an empty buffer with the same-cycle pop ignored is not allowed; res_valid is 0 when empty, so that case cannot occur.
- Sample FIFO: simultaneous push and pop allowed when full. Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is log2(FIFO_DEPTH)+1.
- Coefficient word offered outside IDLE/COEF_FILL: host_ready=0 and it is held off. Samples arriving during a coefficient phase are held off likewise.
- flush has no effect during coefficient states. It is sampled on entry to IDLE.
- Reset mid-burst or mid-stream: the partial burst is abandoned; the FIR sees s_set_coeffs/tvalid drop in the same cycle.

Test Plan:
- Coefficient load: words 0x01,0x03,0x00 with host_valid continuous -> s_set_coeffs=1 for 4 cycles; x_n sequence 01,01,03,00; then 2 gap cycles; coef_done pulses once.
- Full stream: samples 0x10,0x20,0x30,0x40, res_ready=1 -> FIFO full triggers STREAM; tvalid=1 for 4 consecutive cycles with x_n in order; 4 res_valid beats, each carrying y_n sampled exactly Y_LATENCY cycles after its sample; then IDLE, busy=0.
- Backpressure: res_ready=0 with 8 samples queued -> exactly RES_DEPTH results buffered; tvalid stalls; no loss or duplication. res_ready=1 -> remaining results delivered in order.
- Flush: 2 samples (0x05, 0xFB) then flush=1 -> 2 tvalid cycles, 2 results, return to IDLE.
- Hold-off: coefficient word offered while STREAM has 3 entries -> host_ready=0 until IDLE with FIFO empty and in-flight 0; then accepted.
- Async reset: rst_n low during COEF_BURST cycle 2 -> s_set_coeffs, tvalid, res_valid, coef_done all 0 immediately. After release, a fresh 3-word load succeeds.
